psum_accum: RTL and testbench

Partial-sum accumulator sitting directly downstream of the NPU element adder. It consumes a stream of signed adder results over a valid/ready handshake and sums a programmable number of terms into one wide accumulator. It then presents the finished partial sum to the next stage (requantiser/writeback) over a second valid/ready handshake.

---
 rtl/npu_pkg.sv | 25 ++
 rtl/psum_sat_add.sv | 41 ++++
 rtl/psum_accum.sv | 135 +++++++++++++
 tb/tb_psum_accum.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: accumulator FSM states, default widths and the
// saturation limits as functions of the accumulator width.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    // Largest positive value of an acc_w-bit signed number, in the low acc_w bits.
    function automatic logic [63:0] sat_max(input int unsigned acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    // Most negative value of an acc_w-bit signed number, in the low acc_w bits.
    function automatic logic [63:0] sat_min(input int unsigned acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational ACC_W+1-bit add of the accumulator and one sign-extended term.
// Overflow is flagged when the two top bits of the wide sum differ.
// With PSUM_SAT_EN defined the result clamps to the signed limits on
// overflow; otherwise it wraps modulo 2^ACC_W.
module psum_sat_add
    import npu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_term,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0] w_acc_ext;
    logic [ACC_W:0] w_term_ext;
    logic [ACC_W:0] w_sum_ext;

    assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
    assign w_term_ext = (ACC_W+1)'($signed(i_term));
    assign w_sum_ext  = w_acc_ext + w_term_ext;
    assign o_ovf      = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];

`ifdef PSUM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    // Clamp toward the sign of the true sum, which is the top bit of the wide result.
    always_comb begin
        o_sum = w_sum_ext[ACC_W-1:0];
        if (o_ovf) begin
            o_sum = w_sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign o_sum = w_sum_ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums len signed terms from the element adder and
// presents the result over a valid/ready handshake.
// Overflow behaviour follows the PSUM_SAT_EN macro (clamp when defined,
// wrap when undefined); ovf is sticky for the vector either way.
module psum_accum
    import npu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              ovf,
    output logic              busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len_q;
    logic               r_ovf;

    logic               w_beat;
    logic               w_take;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_last_acc;
    logic [ACC_W-1:0]   w_term_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_add_ovf;

    assign w_beat     = in_valid && in_ready;
    assign w_take     = out_valid && out_ready;
    assign w_len_eff  = (len == '0) ? LEN_W'(1) : len;
    assign w_last_acc = (r_cnt + LEN_W'(1)) == r_len_q;
    assign w_term_ext = ACC_W'($signed(in_data));

    psum_sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_term (in_data),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; in_ready depends on state alone.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_beat) begin
                    w_next_state = (w_len_eff == LEN_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (w_beat && w_last_acc) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (w_take) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Accumulator, term counter, latched length and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_acc   <= w_term_ext;
                        r_cnt   <= LEN_W'(1);
                        r_len_q <= w_len_eff;
                        r_ovf   <= 1'b0;
                    end
                end
                ACC: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + LEN_W'(1);
                        r_ovf <= r_ovf | w_add_ovf;
                    end
                end
                HOLD: begin
                    if (w_take) begin
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = r_acc;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a default-width instance and an 8-bit
// accumulator instance share all inputs and run in lockstep.
module tb_psum_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic        ovf;
    logic        busy;

    logic        rdy8;
    logic        val8;
    logic [7:0]  dat8;
    logic        ovf8;
    logic        busy8;

    int n_cmp = 0;
    int n_mis = 0;

    psum_accum #(.DATA_W(8), .ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .len(len), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .ovf(ovf), .busy(busy)
    );

    psum_accum #(.DATA_W(8), .ACC_W(8), .LEN_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .len(len), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .out_valid(val8), .out_ready(out_ready),
        .out_data(dat8), .ovf(ovf8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 24'd0) begin n_mis++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_cmp++; if (ovf !== 1'b0) begin n_mis++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] terms [4];
        terms[0] = 8'd3; terms[1] = 8'hFF; terms[2] = 8'd5; terms[3] = 8'd2;
        len = 8'd4; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = terms[i];
            if (i == 3) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_early_valid: got %b want 0", out_valid); end
                n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_no_bubble: got %b want 1", in_ready); end
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'd9) begin n_mis++; $display("FAIL b2b_data: got %h want 000009", out_data); end
        n_cmp++; if (ovf !== 1'b0) begin n_mis++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_in_ready_hold: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_release: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_len_zero();
        len = 8'd0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hF9;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL len0_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'hFFFFF9) begin n_mis++; $display("FAIL len0_data: got %h want fffff9", out_data); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL len0_busy: got %b want 0", busy); end
    endtask

    task automatic test_gaps_backpressure();
        len = 8'd3; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd10; tick();
        in_valid = 1'b0; tick();
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL gap_busy: got %b want 1", busy); end
        in_valid = 1'b1; in_data = 8'd20; tick();
        in_valid = 1'b0; tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL gap_early_valid: got %b want 0", out_valid); end
        in_valid = 1'b1; in_data = 8'hFB; tick();
        in_data = 8'd99;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 24'd25) begin n_mis++; $display("FAIL bp_data[%0d]: got %h want 000019", i, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_data !== 24'd25) begin n_mis++; $display("FAIL bp_final_data: got %h want 000019", out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_release: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_mid;
        logic [7:0] exp_end;
`ifdef PSUM_SAT_EN
        exp_mid = 8'h7F; exp_end = 8'h4D;
`else
        exp_mid = 8'hC8; exp_end = 8'h96;
`endif
        len = 8'd3; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'd100; tick();
        in_data = 8'd100; tick();
        n_cmp++; if (dat8 !== exp_mid) begin n_mis++; $display("FAIL ovf_mid_acc8: got %h want %h", dat8, exp_mid); end
        n_cmp++; if (ovf8 !== 1'b1) begin n_mis++; $display("FAIL ovf_mid_flag8: got %b want 1", ovf8); end
        n_cmp++; if (ovf !== 1'b0) begin n_mis++; $display("FAIL ovf_mid_flag24: got %b want 0", ovf); end
        in_data = 8'hCE; tick();
        in_valid = 1'b0;
        n_cmp++; if (val8 !== 1'b1) begin n_mis++; $display("FAIL ovf_valid8: got %b want 1", val8); end
        n_cmp++; if (dat8 !== exp_end) begin n_mis++; $display("FAIL ovf_data8: got %h want %h", dat8, exp_end); end
        n_cmp++; if (ovf8 !== 1'b1) begin n_mis++; $display("FAIL ovf_sticky8: got %b want 1", ovf8); end
        n_cmp++; if (out_data !== 24'd150) begin n_mis++; $display("FAIL ovf_data24: got %h want 000096", out_data); end
        tick();
        n_cmp++; if (ovf8 !== 1'b0) begin n_mis++; $display("FAIL ovf_clear8: got %b want 0", ovf8); end
    endtask

    task automatic test_mid_reset();
        len = 8'd4; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'd7; tick();
        in_data = 8'd8; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 24'd0) begin n_mis++; $display("FAIL mrst_out_data: got %h want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL mrst_busy: got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
        len = 8'd2; in_valid = 1'b1;
        in_data = 8'd1; tick();
        in_data = 8'd1; tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL mrst_new_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'd2) begin n_mis++; $display("FAIL mrst_new_data: got %h want 000002", out_data); end
        tick();
    endtask

    task automatic test_len_change();
        len = 8'd2; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'd4; tick();
        len = 8'd5; in_data = 8'd6; tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL lenchg_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 24'd10) begin n_mis++; $display("FAIL lenchg_data: got %h want 00000a", out_data); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL lenchg_idle: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_len_zero();
        test_gaps_backpressure();
        test_overflow();
        test_mid_reset();
        test_len_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
